lfsr_misr_bist_ctrl: RTL and testbench
======================================

Name: lfsr_misr_bist_ctrl

Overview:
Parametrised built-in self-test controller for the team's random-logic combinational benchmark netlists.
- An LFSR drives a programmable number of pseudo-random patterns into the benchmark inputs.
- A MISR compacts the benchmark outputs into a signature, which is compared against a golden value.
- Input width, output width and DUT pipeline latency are generic, so one controller wraps any benchmark variant, including pipelined successors.

Parameters:
IN_W, 10, benchmark input width (LFSR width), >=2
OUT_W, 14, benchmark output width (MISR width), >=2
PAT_CNT_W, 16, width of pattern-count request
DUT_LAT, 0, register stages inside DUT between dut_in and dut_out, 0..7
SEED, 1, LFSR load value on start/reset, must be non-zero (truncated to IN_W)
POLY_IN, 'h240, Galois feedback mask for LFSR (x^10+x^7+1)
POLY_OUT, 'h3802, Galois feedback mask for MISR (x^14+x^13+x^12+x^2+1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin test; sampled only in IDLE or DONE
num_patterns  in  PAT_CNT_W  patterns to apply; sampled on accepted start
golden  in  OUT_W  expected signature; sampled on accepted start
dut_in  out  IN_W  pattern to benchmark inputs (= LFSR state)
dut_out  in  OUT_W  benchmark outputs
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE (level, held until next accepted start)
pass  out  1  signature==golden; valid only while done=1, else 0
signature  out  OUT_W  current MISR contents

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr=SEED, misr=0, counters=0.
  - Outputs: busy=0, done=0, pass=0, signature=0, dut_in=SEED.
  - Asserting rst_n mid-RUN or mid-DRAIN aborts the test with these same values; no partial result is retained.
- Galois step, width W, mask P: s' = {0, s[W-1:1]} ^ (s[0] ? P : 0).
- LFSR: loaded with SEED on accepted start; steps once per RUN cycle. Pattern k = step^k(SEED).
- MISR: m' = step(m) ^ dut_out. Cleared to 0 on accepted start. Absorbs only when the capture-valid shift register (depth DUT_LAT) output is 1.
- Capture-valid shift register: input = (state==RUN). With DUT_LAT=0 it is that signal directly.
- FSM:
  - IDLE: start=1 → latch num_patterns and golden, load lfsr, clear misr. Go to RUN if num_patterns>0, else DONE.
  - RUN: apply one pattern per cycle; remaining-count decrements each cycle. Exactly num_patterns patterns are applied; after the last one, go to DRAIN if DUT_LAT>0, else DONE.
  - DRAIN: wait DUT_LAT cycles so in-flight results are absorbed, then go to DONE.
  - DONE: done=1, pass=(misr==golden_latched). start=1 → same action as from IDLE.
- start in RUN/DRAIN is ignored; num_patterns and golden changes are ignored except on an accepted start.
- Total MISR absorptions per test always equal num_patterns.
- Latency from accepted start to done=1 is num_patterns+DUT_LAT+1 cycles. num_patterns=0 gives 1 cycle, with signature=0.
- Maximum num_patterns = 2^PAT_CNT_W-1. The remaining-count never wraps.
- If the LFSR period is exceeded, the pattern sequence repeats; no flag is raised.
- signature is live during busy and frozen in DONE.

Test Plan:
- Reset: hold rst_n=0, then release → dut_in=0x001, signature=0, busy=done=pass=0.
- LFSR sequence: num_patterns=3, defaults → dut_in over the RUN cycles = 0x001, 0x240, 0x120; done rises 4 cycles after start.
- MISR arithmetic: dut_out tied 0x0001, num_patterns=2, golden=0x3803 → signature 0x0001 then 0x3803; pass=1. Repeat with golden=0x3802 → pass=0.
- Zero patterns: num_patterns=0, golden=0 → done=1 one cycle after start, signature=0, pass=1, busy never asserted.
- DUT_LAT=2: two-register delay model in front of a reference benchmark model, num_patterns=50 → signature equals the DUT_LAT=0 run on the same netlist; DRAIN lasts 2 cycles.
- Robustness:
  - start pulsed mid-RUN → ignored.
  - rst_n pulsed mid-RUN → immediate IDLE reset values.
  - start in DONE → a new test runs and done deasserts the next cycle.

Source files
------------

// File: rtl/lfsr_misr_bist_ctrl.sv
// BIST controller: a Galois LFSR feeds patterns into a benchmark netlist and a
// Galois MISR compacts its responses into a signature checked against golden.
module lfsr_misr_bist_ctrl #(
  parameter int unsigned      IN_W      = 10,
  parameter int unsigned      OUT_W     = 14,
  parameter int unsigned      PAT_CNT_W = 16,
  parameter int unsigned      DUT_LAT   = 0,
  parameter int unsigned      SEED      = 32'd1,
  parameter logic [IN_W-1:0]  POLY_IN   = 10'h240,
  parameter logic [OUT_W-1:0] POLY_OUT  = 14'h3802
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PAT_CNT_W-1:0] num_patterns,
  input  logic [OUT_W-1:0]     golden,
  output logic [IN_W-1:0]      dut_in,
  input  logic [OUT_W-1:0]     dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [OUT_W-1:0]     signature
);

  localparam logic [IN_W-1:0] SEED_V     = IN_W'(SEED);
  localparam logic [2:0]      DRAIN_INIT = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] s);
    logic [IN_W-1:0] fb;
    if (s[0]) fb = POLY_IN;
    else      fb = '0;
    return {1'b0, s[IN_W-1:1]} ^ fb;
  endfunction

  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s);
    logic [OUT_W-1:0] fb;
    if (s[0]) fb = POLY_OUT;
    else      fb = '0;
    return {1'b0, s[OUT_W-1:1]} ^ fb;
  endfunction

  state_t               state_q, state_d;
  logic [IN_W-1:0]      lfsr_q, lfsr_d;
  logic [OUT_W-1:0]     misr_q, misr_d;
  logic [OUT_W-1:0]     golden_q, golden_d;
  logic [PAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 run_s;
  logic                 cap_vld_s;

  assign run_s = (state_q == S_RUN);

  // Capture-valid delay line: marks which cycles carry a response to a RUN pattern.
  generate
    if (DUT_LAT == 0) begin : g_no_lat
      assign cap_vld_s = run_s;
    end else begin : g_lat
      logic [DUT_LAT-1:0] vld_q, vld_d;

      // Shift RUN activity through DUT_LAT stages to match the benchmark pipeline.
      always_comb begin
        vld_d    = '0;
        vld_d[0] = run_s;
        for (int i = 1; i < int'(DUT_LAT); i++) begin
          vld_d[i] = vld_q[i-1];
        end
      end

      // Capture-valid delay line register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
      end

      assign cap_vld_s = vld_q[DUT_LAT-1];
    end
  endgenerate

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    golden_d = golden_q;
    if (cap_vld_s) misr_d = misr_step(misr_q) ^ dut_out;
    else           misr_d = misr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          golden_d = golden;
          lfsr_d   = SEED_V;
          misr_d   = '0;
          cnt_d    = num_patterns;
          if (num_patterns != '0) state_d = S_RUN;
          else                    state_d = S_DONE;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q - PAT_CNT_W'(1);
        // cnt_q==1 means the pattern on dut_in this cycle is the last one.
        if (cnt_q == PAT_CNT_W'(1)) begin
          if (DUT_LAT > 0) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (misr_d == golden_d);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_V;
      misr_q   <= '0;
      golden_q <= '0;
      cnt_q    <= '0;
      drain_q  <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      golden_q <= golden_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in    = lfsr_q;
  assign signature = misr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_lfsr_misr_bist_ctrl.sv
// Directed bench for lfsr_misr_bist_ctrl: instance A has DUT_LAT=0, instance B
// has DUT_LAT=2 behind a two-register delay in front of the same reference netlist.
module tb_lfsr_misr_bist_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, use_model;
  logic [15:0] num_patterns;
  logic [13:0] golden, const_out;
  logic [9:0]  dut_in_a, dut_in_b, d1_q, d2_q;
  logic [13:0] dut_out_a, dut_out_b, sig_a, sig_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [13:0] bench_f(input logic [9:0] x);
    return {x[3:0], x} ^ {x, 4'b0000} ^ 14'h01a5;
  endfunction

  function automatic logic [9:0] gal10(input logic [9:0] s);
    return {1'b0, s[9:1]} ^ (s[0] ? 10'h240 : 10'h000);
  endfunction

  function automatic logic [13:0] gal14(input logic [13:0] s);
    return {1'b0, s[13:1]} ^ (s[0] ? 14'h3802 : 14'h0000);
  endfunction

  assign dut_out_a = use_model ? bench_f(dut_in_a) : const_out;
  always @(posedge clk) begin
    d1_q <= dut_in_b;
    d2_q <= d1_q;
  end
  assign dut_out_b = bench_f(d2_q);

  lfsr_misr_bist_ctrl #(.DUT_LAT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .num_patterns(num_patterns),
    .golden(golden), .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a));

  lfsr_misr_bist_ctrl #(.DUT_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .num_patterns(num_patterns),
    .golden(golden), .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timed_run(input bit use_b, output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      cyc++;
      if (use_b ? busy_b : busy_a) busy_cyc++;
      if (use_b ? done_b : done_a) break;
    end
  endtask

  initial begin
    logic [9:0]  ml;
    logic [13:0] mm, exp_model, exp_five;
    int          cyc, bcyc;

    ml = 10'h001;
    mm = 14'h0000;
    for (int k = 0; k < 50; k++) begin
      mm = gal14(mm) ^ bench_f(ml);
      ml = gal10(ml);
    end
    exp_model = mm;
    mm = 14'h0000;
    for (int k = 0; k < 5; k++) mm = gal14(mm) ^ 14'h0001;
    exp_five = mm;

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; use_model = 1'b0;
    num_patterns = 16'd0; golden = 14'h0000; const_out = 14'h0000;
    repeat (3) @(negedge clk);
    check("rst_hold_dut_in", 32'(dut_in_a), 32'h001);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_dut_in", 32'(dut_in_a), 32'h001);
    check("rst_sig", 32'(sig_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_pass", 32'(pass_a), 32'h0);

    // LFSR sequence, 3 patterns
    num_patterns = 16'd3; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("lfsr_p0", 32'(dut_in_a), 32'h001);
    check("lfsr_busy", 32'(busy_a), 32'h1);
    @(negedge clk);
    check("lfsr_p1", 32'(dut_in_a), 32'h240);
    @(negedge clk);
    check("lfsr_p2", 32'(dut_in_a), 32'h120);
    check("lfsr_done_early", 32'(done_a), 32'h0);
    @(negedge clk);
    check("lfsr_done", 32'(done_a), 32'h1);
    check("lfsr_busy_end", 32'(busy_a), 32'h0);
    check("lfsr_pass", 32'(pass_a), 32'h1);

    // MISR arithmetic, restarted from DONE
    const_out = 14'h0001; num_patterns = 16'd2; golden = 14'h3803; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("misr_done_drop", 32'(done_a), 32'h0);
    check("misr_pass_low", 32'(pass_a), 32'h0);
    @(negedge clk);
    check("misr_sig1", 32'(sig_a), 32'h0001);
    @(negedge clk);
    check("misr_sig2", 32'(sig_a), 32'h3803);
    check("misr_done", 32'(done_a), 32'h1);
    check("misr_pass", 32'(pass_a), 32'h1);
    golden = 14'h3802; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("misr_bad_sig", 32'(sig_a), 32'h3803);
    check("misr_bad_done", 32'(done_a), 32'h1);
    check("misr_bad_pass", 32'(pass_a), 32'h0);

    // Reference netlist, DUT_LAT 0 and 2
    use_model = 1'b1; num_patterns = 16'd50; golden = exp_model;
    timed_run(1'b0, cyc, bcyc);
    check("lat0_cycles", 32'(cyc), 32'd51);
    check("lat0_busy_cycles", 32'(bcyc), 32'd50);
    check("lat0_sig", 32'(sig_a), 32'(exp_model));
    check("lat0_pass", 32'(pass_a), 32'h1);
    timed_run(1'b1, cyc, bcyc);
    check("lat2_cycles", 32'(cyc), 32'd53);
    check("lat2_busy_cycles", 32'(bcyc), 32'd52);
    check("lat2_sig", 32'(sig_b), 32'(exp_model));
    check("lat2_pass", 32'(pass_b), 32'h1);

    // start pulsed mid-RUN is ignored
    use_model = 1'b0; const_out = 14'h0001; num_patterns = 16'd5; golden = exp_five;
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1; num_patterns = 16'd1;
    @(negedge clk); start_a = 1'b0; num_patterns = 16'd5;
    @(negedge clk);
    @(negedge clk);
    check("midstart_done_early", 32'(done_a), 32'h0);
    check("midstart_busy", 32'(busy_a), 32'h1);
    @(negedge clk);
    check("midstart_done", 32'(done_a), 32'h1);
    check("midstart_sig", 32'(sig_a), 32'(exp_five));
    check("midstart_pass", 32'(pass_a), 32'h1);

    // rst_n pulsed mid-RUN
    num_patterns = 16'd10; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_a), 32'h0);
    check("abort_dut_in", 32'(dut_in_a), 32'h001);
    check("abort_sig", 32'(sig_a), 32'h0);
    check("abort_done", 32'(done_a), 32'h0);
    check("abort_pass", 32'(pass_a), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", 32'(busy_a), 32'h0);
    check("abort_idle_done", 32'(done_a), 32'h0);

    // Zero patterns from IDLE
    num_patterns = 16'd0; golden = 14'h0000; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("zero_done", 32'(done_a), 32'h1);
    check("zero_busy", 32'(busy_a), 32'h0);
    check("zero_sig", 32'(sig_a), 32'h0);
    check("zero_pass", 32'(pass_a), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
